// File: rtl/io_write_arbiter.sv
// io_write_arbiter: shares the single memory-mapped I/O write bus between two
// write masters (req0 = CPU store path, req1 = secondary master).
// It issues one registered write per cycle with a one-cycle ack per requester.
// Optional macro ARB_FIXED_PRIO_EN: when defined, requester 0 always wins a tie.
// When it is undefined, ties are broken round-robin using rr_last.
module io_write_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] regData,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] regdata_q, regdata_d;

  logic elig0, elig1;
  logic tie_pick1;

  // A requester whose ack is high this cycle presents a stale req, so it is masked.
  always_comb begin
    elig0 = req0 && (state_q != WR0);
    elig1 = req1 && (state_q != WR1);
  end

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always takes a tie.
  always_comb begin
    tie_pick1 = 1'b0;
  end
`else
  // Round-robin: a tie goes to the requester that was not served last.
  always_comb begin
    tie_pick1 = ~rr_last_q;
  end
`endif

  // Next-state selection and address/data capture for the granted requester.
  always_comb begin
    state_d   = IDLE;
    rr_last_d = rr_last_q;
    address_d = address_q;
    regdata_d = regdata_q;
    if (elig1 && (!elig0 || tie_pick1)) begin
      state_d   = WR1;
      rr_last_d = 1'b1;
      address_d = addr1;
      regdata_d = data1;
    end else if (elig0) begin
      state_d   = WR0;
      rr_last_d = 1'b0;
      address_d = addr0;
      regdata_d = data0;
    end
  end

  // State and capture registers. Asynchronous reset aborts any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      address_q <= '0;
      regdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      address_q <= address_d;
      regdata_q <= regdata_d;
    end
  end

  // Bus and handshake outputs are decoded directly from the registered state.
  always_comb begin
    ack0    = (state_q == WR0);
    ack1    = (state_q == WR1);
    we      = (state_q != IDLE);
    grant   = {ack1, ack0};
    address = address_q;
    regData = regdata_q;
  end

endmodule

// File: tb/tb_io_write_arbiter.sv
// Testbench for io_write_arbiter: directed scenarios followed by randomized traffic.
// Outputs are compared against a behavioural model of the request/ack protocol.
module tb_io_write_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              ack0, ack1, we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] regData;
  logic [1:0]        grant;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: which requester was acked in the current cycle,
  // who was served most recently, and the value currently held on the bus.
  logic [1:0]        m_ack;
  logic              m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  io_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .addr0   (addr0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .addr1   (addr1),
    .data1   (data1),
    .ack1    (ack1),
    .we      (we),
    .address (address),
    .regData (regData),
    .grant   (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ack  = 2'b00;
    m_last = 1'b1;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock edge of the model: a request is pending unless it was just acked.
  // A single pending requester wins; with two pending, the tie rule picks one.
  task automatic model_edge();
    logic [1:0] pend;
    int         winner;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pend   = {req1 & ~m_ack[1], req0 & ~m_ack[0]};
    winner = -1;
    if (pend == 2'b01) winner = 0;
    else if (pend == 2'b10) winner = 1;
    else if (pend == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = 0;
`else
      winner = (m_last == 1'b1) ? 0 : 1;
`endif
    end
    if (winner == 0) begin
      m_ack  = 2'b01;
      m_last = 1'b0;
      m_addr = addr0;
      m_data = data0;
    end else if (winner == 1) begin
      m_ack  = 2'b10;
      m_last = 1'b1;
      m_addr = addr1;
      m_data = data1;
    end else begin
      m_ack = 2'b00;
    end
  endtask

  task automatic check_model();
    chk("model_we",      32'(we),      32'(m_ack != 2'b00));
    chk("model_ack0",    32'(ack0),    32'(m_ack[0]));
    chk("model_ack1",    32'(ack1),    32'(m_ack[1]));
    chk("model_grant",   32'(grant),   32'(m_ack));
    chk("model_address", 32'(address), 32'(m_addr));
    chk("model_regData", 32'(regData), 32'(m_data));
  endtask

  // Advance one clock: update the model at the edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous reset pulse placed between clock edges, outputs checked while low.
  task automatic mid_cycle_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_we"},    32'(we),      32'h0);
    chk({tag, "_ack0"},  32'(ack0),    32'h0);
    chk({tag, "_ack1"},  32'(ack1),    32'h0);
    chk({tag, "_grant"}, 32'(grant),   32'h0);
    chk({tag, "_addr"},  32'(address), 32'h0);
    chk({tag, "_data"},  32'(regData), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset with both requesters already active.
    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 8'hFF;
    addr1 = 8'hFF;
    data0 = 8'h11;
    data1 = 8'h22;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_we",    32'(we),      32'h0);
    chk("rst_ack0",  32'(ack0),    32'h0);
    chk("rst_ack1",  32'(ack1),    32'h0);
    chk("rst_grant", 32'(grant),   32'h0);
    chk("rst_addr",  32'(address), 32'h0);
    chk("rst_data",  32'(regData), 32'h0);
    rst_n = 1'b1;

    // Both held high: writes alternate 0,1,0,1,0 on every cycle.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("alt_grant", 32'(grant),   (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_data",  32'(regData), (i % 2 == 0) ? 32'h11 : 32'h22);
      chk("alt_we",    32'(we),      32'h1);
      chk("alt_addr",  32'(address), 32'hFF);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk("idle_we",    32'(we),      32'h0);
    chk("idle_grant", 32'(grant),   32'h0);
    chk("idle_hold",  32'(address), 32'hFF);

    // Simultaneous rise after requester 0 was served last.
    addr0 = 8'h10; data0 = 8'h33;
    addr1 = 8'h20; data1 = 8'h44;
    req0  = 1'b1;
    req1  = 1'b1;
    step();
`ifdef ARB_FIXED_PRIO_EN
    chk("tie_first_ack0", 32'(ack0),    32'h1);
    chk("tie_first_data", 32'(regData), 32'h33);
    req0 = 1'b0;
`else
    chk("tie_first_ack1", 32'(ack1),    32'h1);
    chk("tie_first_data", 32'(regData), 32'h44);
    req1 = 1'b0;
`endif
    step();
`ifdef ARB_FIXED_PRIO_EN
    chk("tie_second_ack1", 32'(ack1),    32'h1);
    chk("tie_second_addr", 32'(address), 32'h20);
    req1 = 1'b0;
`else
    chk("tie_second_ack0", 32'(ack0),    32'h1);
    chk("tie_second_addr", 32'(address), 32'h10);
    req0 = 1'b0;
`endif
    step();
    chk("tie_idle_we", 32'(we), 32'h0);

    // Single write from requester 0 to address FF.
    addr0 = 8'hFF;
    data0 = 8'hA5;
    req0  = 1'b1;
    step();
    chk("single_we",    32'(we),      32'h1);
    chk("single_addr",  32'(address), 32'hFF);
    chk("single_data",  32'(regData), 32'hA5);
    chk("single_ack0",  32'(ack0),    32'h1);
    chk("single_grant", 32'(grant),   32'h1);
    req0 = 1'b0;
    step();
    chk("single_ack_once", 32'(ack0), 32'h0);
    chk("single_we_off",   32'(we),   32'h0);

    // Request withdrawn before it is sampled.
    req0 = 1'b1;
    #2 req0 = 1'b0;
    step();
    chk("withdraw_we",    32'(we),    32'h0);
    chk("withdraw_ack0",  32'(ack0),  32'h0);
    chk("withdraw_grant", 32'(grant), 32'h0);

    // Reset in the middle of a requester 1 write; the held request is re-served.
    addr1 = 8'h42;
    data1 = 8'h5A;
    req1  = 1'b1;
    step();
    chk("pre_rst_ack1", 32'(ack1), 32'h1);
    mid_cycle_reset("midrst");
    step();
    chk("post_rst_ack1", 32'(ack1),    32'h1);
    chk("post_rst_data", 32'(regData), 32'h5A);
    req1 = 1'b0;
    step();

    // Randomized traffic obeying the request/ack protocol.
    for (int c = 0; c < 600; c++) begin
      step();
      if (m_ack[0]) begin
        req0 = 1'($urandom_range(0, 1));
        addr0 = 8'($urandom);
        data0 = 8'($urandom);
      end else if (req0) begin
        if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req0  = 1'b1;
        addr0 = 8'($urandom);
        data0 = 8'($urandom);
      end
      if (m_ack[1]) begin
        req1 = 1'($urandom_range(0, 1));
        addr1 = 8'($urandom);
        data1 = 8'($urandom);
      end else if (req1) begin
        if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req1  = 1'b1;
        addr1 = 8'($urandom);
        data1 = 8'($urandom);
      end
      if ($urandom_range(0, 149) == 0) mid_cycle_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
